// File: rtl/xlgmii_tx_adapter.sv
// xlgmii_tx_adapter
// Converts a 32-byte/beat valid/ready frame stream into the 4-lane XLGMII
// view that pcs_40g_tx consumes. It inserts the preamble/SFD start lane,
// realigns the payload by one lane, places the terminate (or error) lane,
// and enforces the minimum inter-packet gap.
//
// Lane 0 of every data cycle carries the last 8 bytes of the previous beat
// (the "carry"), because the start lane pushes the whole frame up by one lane.
//
// Ports
//   clk, nreset                 clock, asynchronous active-low reset
//   s_valid_i/s_ready_o         input beat handshake
//   s_data_i/s_keep_i           32-byte payload, byte 0 in bits [7:0], contiguous keep
//   s_last_i/s_err_i            last beat of frame / frame bad (sampled on last beat)
//   pcs_ready_i                 PCS ready; low freezes this block completely
//   ctrl_v_o..err_v_o           per-lane control/idle/start/terminate/error flags
//   data_o/keep_o               per-lane data and valid-byte count (0..8)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | between frames; all-idle lanes, waiting for the first beat
// DATA    | mid-frame; each accepted beat emits carry + 24 payload bytes
// TAIL    | extra output cycle draining the carry after a long last beat
// IPG     | inter-packet gap; all-idle lanes, input held off
module xlgmii_tx_adapter #(
  parameter int LANE_N  = 4,
  parameter int DATA_W  = 64,
  parameter int KEEP_W  = $clog2(DATA_W),
  parameter int IPG_CYC = 1
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       s_valid_i,
  output logic                       s_ready_o,
  input  logic [LANE_N*DATA_W-1:0]   s_data_i,
  input  logic [LANE_N*DATA_W/8-1:0] s_keep_i,
  input  logic                       s_last_i,
  input  logic                       s_err_i,
  input  logic                       pcs_ready_i,
  output logic [LANE_N-1:0]          ctrl_v_o,
  output logic [LANE_N-1:0]          idle_v_o,
  output logic [LANE_N-1:0]          start_v_o,
  output logic [LANE_N-1:0]          term_v_o,
  output logic [LANE_N-1:0]          err_v_o,
  output logic [LANE_N*DATA_W-1:0]   data_o,
  output logic [LANE_N*KEEP_W-1:0]   keep_o
);

  localparam logic [63:0]       PREAMBLE  = 64'hD555_5555_5555_5555;
  localparam logic [KEEP_W-1:0] KEEP_FULL = KEEP_W'(8);
  localparam logic [2:0]        IPG_LOAD  = 3'(IPG_CYC);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_TAIL, ST_IPG} state_t;

  state_t      state, nx_state;
  logic [63:0] carry, nx_carry;
  logic [3:0]  tail_n, nx_tail_n;
  logic        frame_err, nx_frame_err;
  logic [2:0]  ipg_cnt, nx_ipg;

  logic [LANE_N-1:0]        nx_ctrl, nx_idle, nx_start, nx_term, nx_err;
  logic [LANE_N*DATA_W-1:0] nx_data;
  logic [LANE_N*KEEP_W-1:0] nx_keep;

  logic       accept, beat_bad, err_now;
  logic [5:0] beat_n;

  // Keep only the first n bytes of a lane; bytes past the terminate are zero.
  function automatic logic [63:0] mask_bytes(input logic [63:0] d, input logic [3:0] n);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < 8; b++)
      if (4'(b) < n) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  assign s_ready_o = pcs_ready_i & nreset & ((state == ST_IDLE) | (state == ST_DATA));
  assign accept    = s_valid_i & s_ready_o;
  // A short non-last beat corrupts the frame; it is flagged on the terminate lane.
  assign beat_bad  = ~s_last_i & (s_keep_i != '1);
  assign err_now   = frame_err | s_err_i;

  always_comb begin
    beat_n = '0;
    for (int i = 0; i < LANE_N*DATA_W/8; i++)
      beat_n = beat_n + 6'(s_keep_i[i]);
  end

  always_comb begin
    nx_ctrl      = '1;
    nx_idle      = '1;
    nx_start     = '0;
    nx_term      = '0;
    nx_err       = '0;
    nx_data      = '0;
    nx_keep      = '0;
    nx_state     = state;
    nx_carry     = carry;
    nx_tail_n    = tail_n;
    nx_frame_err = frame_err;
    nx_ipg       = ipg_cnt;

    case (state)
      ST_IDLE, ST_DATA: begin
        // An empty last beat with no frame open carries nothing; drop it.
        if (accept && !(state == ST_IDLE && s_last_i && s_keep_i == '0)) begin
          nx_ctrl[0]  = (state == ST_IDLE);
          nx_idle[0]  = 1'b0;
          nx_start[0] = (state == ST_IDLE);
          nx_data[63:0] = (state == ST_IDLE) ? PREAMBLE : carry;
          nx_keep[KEEP_W-1:0] = KEEP_FULL;
          if (!s_last_i) begin
            for (int l = 1; l < LANE_N; l++) begin
              nx_ctrl[l] = 1'b0;
              nx_idle[l] = 1'b0;
              nx_data[64*l +: 64] = s_data_i[64*(l-1) +: 64];
              nx_keep[KEEP_W*l +: KEEP_W] = KEEP_FULL;
            end
            nx_carry     = s_data_i[255:192];
            nx_state     = ST_DATA;
            nx_frame_err = frame_err | beat_bad;
          end else begin
            for (int k = 0; k < LANE_N-1; k++) begin
              if (beat_n[5:3] > 3'(k)) begin
                nx_ctrl[k+1] = 1'b0;
                nx_idle[k+1] = 1'b0;
                nx_data[64*(k+1) +: 64] = s_data_i[64*k +: 64];
                nx_keep[KEEP_W*(k+1) +: KEEP_W] = KEEP_FULL;
              end else if (beat_n[5:3] == 3'(k)) begin
                nx_ctrl[k+1] = 1'b1;
                nx_idle[k+1] = 1'b0;
                nx_term[k+1] = ~err_now;
                nx_err[k+1]  = err_now;
                nx_data[64*(k+1) +: 64] = mask_bytes(s_data_i[64*k +: 64], {1'b0, beat_n[2:0]});
                nx_keep[KEEP_W*(k+1) +: KEEP_W] = KEEP_W'(beat_n[2:0]);
              end
            end
            if (beat_n >= 6'd24) begin
              // Terminate does not fit this cycle; bytes 24..31 drain in TAIL.
              nx_state     = ST_TAIL;
              nx_tail_n    = 4'(beat_n - 6'd24);
              nx_carry     = s_data_i[255:192];
              nx_frame_err = err_now;
            end else begin
              nx_state     = ST_IPG;
              nx_ipg       = IPG_LOAD;
              nx_frame_err = 1'b0;
            end
          end
        end
      end

      ST_TAIL: begin
        if (tail_n == 4'd8) begin
          nx_ctrl[0] = 1'b0;
          nx_idle[0] = 1'b0;
          nx_data[63:0] = carry;
          nx_keep[KEEP_W-1:0] = KEEP_FULL;
          nx_ctrl[1] = 1'b1;
          nx_idle[1] = 1'b0;
          nx_term[1] = ~frame_err;
          nx_err[1]  = frame_err;
        end else begin
          nx_ctrl[0] = 1'b1;
          nx_idle[0] = 1'b0;
          nx_term[0] = ~frame_err;
          nx_err[0]  = frame_err;
          nx_data[63:0] = mask_bytes(carry, tail_n);
          nx_keep[KEEP_W-1:0] = KEEP_W'(tail_n);
        end
        nx_state     = ST_IPG;
        nx_ipg       = IPG_LOAD;
        nx_frame_err = 1'b0;
      end

      ST_IPG: begin
        if (ipg_cnt <= 3'd1) begin
          nx_state = ST_IDLE;
          nx_ipg   = '0;
        end else begin
          nx_ipg = ipg_cnt - 3'd1;
        end
      end

      default: nx_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= ST_IDLE;
      carry     <= '0;
      tail_n    <= '0;
      frame_err <= 1'b0;
      ipg_cnt   <= '0;
      ctrl_v_o  <= '1;
      idle_v_o  <= '1;
      start_v_o <= '0;
      term_v_o  <= '0;
      err_v_o   <= '0;
      data_o    <= '0;
      keep_o    <= '0;
    end else if (pcs_ready_i) begin
      state     <= nx_state;
      carry     <= nx_carry;
      tail_n    <= nx_tail_n;
      frame_err <= nx_frame_err;
      ipg_cnt   <= nx_ipg;
      ctrl_v_o  <= nx_ctrl;
      idle_v_o  <= nx_idle;
      start_v_o <= nx_start;
      term_v_o  <= nx_term;
      err_v_o   <= nx_err;
      data_o    <= nx_data;
      keep_o    <= nx_keep;
    end
  end

endmodule

// File: tb/tb_xlgmii_tx_adapter.sv
// Directed scoreboard bench for xlgmii_tx_adapter.
module tb_xlgmii_tx_adapter;

  localparam int K_IDLE  = 0;
  localparam int K_START = 1;
  localparam int K_DATA  = 2;
  localparam int K_TERM  = 3;
  localparam int K_ERR   = 4;

  logic         clk = 1'b0;
  logic         nreset;
  logic         s_valid_i, s_ready_o, s_last_i, s_err_i, pcs_ready_i;
  logic [255:0] s_data_i;
  logic [31:0]  s_keep_i;
  logic [3:0]   ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o;
  logic [255:0] data_o;
  logic [23:0]  keep_o;

  always #5 clk = ~clk;

  xlgmii_tx_adapter #(.IPG_CYC(1)) dut (
    .clk(clk), .nreset(nreset),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_data_i(s_data_i), .s_keep_i(s_keep_i),
    .s_last_i(s_last_i), .s_err_i(s_err_i),
    .pcs_ready_i(pcs_ready_i),
    .ctrl_v_o(ctrl_v_o), .idle_v_o(idle_v_o), .start_v_o(start_v_o),
    .term_v_o(term_v_o), .err_v_o(err_v_o),
    .data_o(data_o), .keep_o(keep_o)
  );

  typedef struct {
    string        tag;
    logic [3:0]   ctrl, idle, start, term, err;
    logic [255:0] data, dmask;
    logic [23:0]  keep, kmask;
    logic         rdy;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  logic [255:0] b1, b2, b3;

  function automatic logic [255:0] mk_beat(input logic [7:0] base);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = base + 8'(i);
    return r;
  endfunction

  function automatic logic [63:0] lane(input logic [255:0] b, input int i);
    return b[64*i +: 64];
  endfunction

  function automatic logic [31:0] keep_n(input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  task automatic new_exp(input string tag, input logic rdy);
    cur.tag   = tag;
    cur.ctrl  = 4'hF;
    cur.idle  = 4'hF;
    cur.start = 4'h0;
    cur.term  = 4'h0;
    cur.err   = 4'h0;
    cur.data  = '0;
    cur.dmask = '0;
    cur.keep  = '0;
    cur.kmask = '1;
    cur.rdy   = rdy;
  endtask

  task automatic set_lane(input int l, input int kind, input logic [63:0] d, input int kp);
    case (kind)
      K_START: begin
        cur.ctrl[l] = 1'b1; cur.idle[l] = 1'b0; cur.start[l] = 1'b1;
        cur.data[64*l +: 64]  = 64'hD555_5555_5555_5555;
        cur.dmask[64*l +: 64] = '1;
        cur.kmask[6*l +: 6]   = '0;
      end
      K_DATA: begin
        cur.ctrl[l] = 1'b0; cur.idle[l] = 1'b0;
        cur.data[64*l +: 64]  = d;
        cur.dmask[64*l +: 64] = '1;
        cur.keep[6*l +: 6]    = 6'd8;
      end
      K_TERM, K_ERR: begin
        cur.ctrl[l] = 1'b1; cur.idle[l] = 1'b0;
        cur.term[l] = (kind == K_TERM);
        cur.err[l]  = (kind == K_ERR);
        cur.keep[6*l +: 6] = 6'(kp);
        for (int b = 0; b < kp; b++) begin
          cur.data[64*l + 8*b +: 8]  = d[8*b +: 8];
          cur.dmask[64*l + 8*b +: 8] = 8'hFF;
        end
      end
      default: ;
    endcase
  endtask

  task automatic push();
    sb.push_back(cur);
  endtask

  task automatic compare_now();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty got=0 exp=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".ctrl"},  256'(ctrl_v_o),  256'(e.ctrl));
      chk({e.tag, ".idle"},  256'(idle_v_o),  256'(e.idle));
      chk({e.tag, ".start"}, 256'(start_v_o), 256'(e.start));
      chk({e.tag, ".term"},  256'(term_v_o),  256'(e.term));
      chk({e.tag, ".err"},   256'(err_v_o),   256'(e.err));
      chk({e.tag, ".data"},  data_o & e.dmask, e.data & e.dmask);
      chk({e.tag, ".keep"},  256'(keep_o & e.kmask), 256'(e.keep & e.kmask));
      chk({e.tag, ".ready"}, 256'(s_ready_o), 256'(e.rdy));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    compare_now();
  endtask

  task automatic drive(input logic [255:0] d, input logic [31:0] k, input logic l, input logic e);
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_keep_i  = k;
    s_last_i  = l;
    s_err_i   = e;
  endtask

  task automatic exp_full_beat(input string tag, input logic rdy, input logic first,
                               input logic [63:0] l0, input logic [255:0] b);
    new_exp(tag, rdy);
    if (first) set_lane(0, K_START, '0, 0);
    else       set_lane(0, K_DATA, l0, 8);
    for (int i = 1; i < 4; i++) set_lane(i, K_DATA, lane(b, i-1), 8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset = 1'b0; pcs_ready_i = 1'b1;
    s_valid_i = 1'b0; s_data_i = '0; s_keep_i = '0; s_last_i = 1'b0; s_err_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    new_exp("reset", 1'b0); cur.dmask = '1; push(); compare_now();
    nreset = 1'b1;
    new_exp("idle", 1'b1); cur.dmask = '1; push(); step();

    // single beat, 16 bytes
    b1 = mk_beat(8'h00);
    drive(b1, keep_n(16), 1'b1, 1'b0);
    new_exp("n16", 1'b0);
    set_lane(0, K_START, '0, 0);
    set_lane(1, K_DATA, 64'h0706_0504_0302_0100, 8);
    set_lane(2, K_DATA, 64'h0F0E_0D0C_0B0A_0908, 8);
    set_lane(3, K_TERM, '0, 0);
    push(); step();
    s_valid_i = 1'b0;
    new_exp("n16_ipg", 1'b1); push(); step();

    // two full beats
    b1 = mk_beat(8'h20); b2 = mk_beat(8'h40);
    drive(b1, '1, 1'b0, 1'b0);
    exp_full_beat("b32_1", 1'b1, 1'b1, '0, b1); push(); step();
    drive(b2, '1, 1'b1, 1'b0);
    exp_full_beat("b32_2", 1'b0, 1'b0, lane(b1, 3), b2); push(); step();
    s_valid_i = 1'b0;
    new_exp("b32_tail", 1'b0);
    set_lane(0, K_DATA, lane(b2, 3), 8);
    set_lane(1, K_TERM, '0, 0);
    push(); step();
    new_exp("b32_ipg", 1'b1); push(); step();

    // n=27 with error
    b1 = mk_beat(8'h60);
    drive(b1, keep_n(27), 1'b1, 1'b1);
    exp_full_beat("n27_1", 1'b0, 1'b1, '0, b1); push(); step();
    s_valid_i = 1'b0;
    new_exp("n27_tail", 1'b0); set_lane(0, K_ERR, lane(b1, 3), 3); push(); step();
    new_exp("n27_ipg", 1'b1); push(); step();

    // n=24: terminate spills into its own cycle
    b1 = mk_beat(8'h80);
    drive(b1, keep_n(24), 1'b1, 1'b0);
    exp_full_beat("n24_1", 1'b0, 1'b1, '0, b1); push(); step();
    s_valid_i = 1'b0;
    new_exp("n24_tail", 1'b0); set_lane(0, K_TERM, '0, 0); push(); step();
    new_exp("n24_ipg", 1'b1); push(); step();

    // n=23: terminate on lane 3
    b1 = mk_beat(8'hA0);
    drive(b1, keep_n(23), 1'b1, 1'b0);
    new_exp("n23", 1'b0);
    set_lane(0, K_START, '0, 0);
    set_lane(1, K_DATA, lane(b1, 0), 8);
    set_lane(2, K_DATA, lane(b1, 1), 8);
    set_lane(3, K_TERM, lane(b1, 2), 7);
    push(); step();
    s_valid_i = 1'b0;
    new_exp("n23_ipg", 1'b1); push(); step();

    // full beat then 5-byte last beat
    b1 = mk_beat(8'h11); b2 = mk_beat(8'h51);
    drive(b1, '1, 1'b0, 1'b0);
    exp_full_beat("n5_1", 1'b1, 1'b1, '0, b1); push(); step();
    drive(b2, keep_n(5), 1'b1, 1'b0);
    new_exp("n5_2", 1'b0);
    set_lane(0, K_DATA, lane(b1, 3), 8);
    set_lane(1, K_TERM, lane(b2, 0), 5);
    push(); step();
    s_valid_i = 1'b0;
    new_exp("n5_ipg", 1'b1); push(); step();

    // short non-last beat, then empty last beat -> error on lane 1
    b1 = mk_beat(8'hC0); b2 = mk_beat(8'hE0);
    drive(b1, keep_n(16), 1'b0, 1'b0);
    exp_full_beat("bad_1", 1'b1, 1'b1, '0, b1);
    cur.dmask[255:192] = '0;
    push(); step();
    drive(b2, '0, 1'b1, 1'b0);
    new_exp("bad_2", 1'b0);
    set_lane(0, K_DATA, '0, 8);
    cur.dmask[63:0] = '0;
    set_lane(1, K_ERR, '0, 0);
    push(); step();
    s_valid_i = 1'b0;
    new_exp("bad_ipg", 1'b1); push(); step();

    // PCS stall mid-frame
    b1 = mk_beat(8'h10); b2 = mk_beat(8'h50); b3 = mk_beat(8'h90);
    drive(b1, '1, 1'b0, 1'b0);
    exp_full_beat("stl_1", 1'b1, 1'b1, '0, b1); push(); step();
    drive(b2, '1, 1'b0, 1'b0);
    pcs_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_full_beat("stl_hold", 1'b0, 1'b1, '0, b1); push(); step();
    end
    pcs_ready_i = 1'b1;
    exp_full_beat("stl_2", 1'b1, 1'b0, lane(b1, 3), b2); push(); step();
    drive(b3, keep_n(8), 1'b1, 1'b0);
    new_exp("stl_3", 1'b0);
    set_lane(0, K_DATA, lane(b2, 3), 8);
    set_lane(1, K_DATA, lane(b3, 0), 8);
    set_lane(2, K_TERM, '0, 0);
    push(); step();
    s_valid_i = 1'b0;
    new_exp("stl_ipg", 1'b1); push(); step();

    // asynchronous reset during DATA
    b1 = mk_beat(8'h30); b2 = mk_beat(8'h70);
    drive(b1, '1, 1'b0, 1'b0);
    exp_full_beat("ar_1", 1'b1, 1'b1, '0, b1); push(); step();
    s_valid_i = 1'b0;
    #2;
    nreset = 1'b0;
    #1;
    new_exp("ar_rst", 1'b0); cur.dmask = '1; push(); compare_now();
    @(posedge clk);
    #1;
    nreset = 1'b1;
    drive(b2, keep_n(16), 1'b1, 1'b0);
    new_exp("ar_new", 1'b0);
    set_lane(0, K_START, '0, 0);
    set_lane(1, K_DATA, lane(b2, 0), 8);
    set_lane(2, K_DATA, lane(b2, 1), 8);
    set_lane(3, K_TERM, '0, 0);
    push(); step();
    s_valid_i = 1'b0;
    new_exp("ar_ipg", 1'b1); push(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
